// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time over a valid/ready request, completes it
// LATENCY cycles later with a one-cycle response pulse, and holds the
// pipeline through op_stall while the access is outstanding.
//
// Ports:
//   clock, reset    - system clock, synchronous active-high reset
//   ip_req_valid    - request present
//   ip_req_write    - 1 = store, 0 = load
//   ip_req_addr     - byte address; word index is addr[ADDR_W+1:2]
//   ip_req_wdata    - store data
//   op_req_ready    - request can be accepted this cycle (IDLE)
//   op_resp_valid   - one-cycle completion pulse (RESP)
//   op_resp_rdata   - load data, zero on a misaligned response, held otherwise
//   op_resp_err     - misaligned access flag, qualified by op_resp_valid
//   op_stall        - pipeline hold: (IDLE && ip_req_valid) || WAIT
module dmem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_req_valid,
  input  logic              ip_req_write,
  input  logic [31:0]       ip_req_addr,
  input  logic [DATA_W-1:0] ip_req_wdata,
  output logic              op_req_ready,
  output logic              op_resp_valid,
  output logic [DATA_W-1:0] op_resp_rdata,
  output logic              op_resp_err,
  output logic              op_stall
);

  localparam int unsigned LOW_W = ADDR_W + 2;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               accept;
  logic               access;

  logic               wr_q;
  logic [LOW_W-1:0]   addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               acc_write;
  logic [LOW_W-1:0]   acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [ADDR_W-1:0]  acc_idx;
  logic               acc_misaligned;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Address bits above the word index are ignored (wrap-around).
  logic               unused_addr_hi;
  assign unused_addr_hi = ^ip_req_addr[31:LOW_W];

  // Next state, counter and handshake outputs.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    accept        = 1'b0;
    access        = 1'b0;
    op_req_ready  = 1'b0;
    op_resp_valid = 1'b0;
    op_stall      = 1'b0;
    case (state)
      IDLE: begin
        op_req_ready = 1'b1;
        op_stall     = ip_req_valid;
        if (ip_req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        op_stall = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        op_resp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Request latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= ip_req_write;
      addr_q  <= ip_req_addr[LOW_W-1:0];
      wdata_q <= ip_req_wdata;
    end
  end

  // With LATENCY=1 the access happens on the accepting edge, so it must use
  // the live request rather than the latch.
  always_comb begin
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_write = ip_req_write;
      acc_addr  = ip_req_addr[LOW_W-1:0];
      acc_wdata = ip_req_wdata;
    end
  end

  assign acc_idx        = acc_addr[LOW_W-1:2];
  assign acc_misaligned = (acc_addr[1:0] != 2'b00);

  // Response data; stores leave rdata untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_resp_rdata <= '0;
      op_resp_err   <= 1'b0;
    end else if (access) begin
      op_resp_err <= acc_misaligned;
      if (acc_misaligned) begin
        op_resp_rdata <= '0;
      end else if (!acc_write) begin
        op_resp_rdata <= mem[acc_idx];
      end
    end
  end

  // Storage is not reset; reset on the commit edge drops the store.
  always_ff @(posedge clock) begin
    if (!reset && access && acc_write && !acc_misaligned) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
